// File: rtl/conv_mem_pkg.sv
// Shared types and constants for the conv-layer output-memory write path.
// Holds the run-state encoding, default layer geometry and the helper
// used to range-check the highest address a configuration can generate.
package conv_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // conv1: 12x12 output map, 5x5 kernel
   localparam int CONV1_OUTS   = 144;
   localparam int CONV1_STRIDE = 144;
   localparam int CONV1_CYCLES = 25;

   // conv2: 4x4 output map, 5x5 kernel over 6 input channels
   localparam int CONV2_OUTS   = 16;
   localparam int CONV2_STRIDE = 16;
   localparam int CONV2_CYCLES = 150;

   // Highest address written by any port during a complete run.
   function automatic longint conv_last_addr(input longint base,
                                             input longint stride,
                                             input int     num_ports,
                                             input int     outs);
      return base + longint'(num_ports - 1) * stride + longint'(outs) - 1;
   endfunction

endpackage

// File: rtl/cycle_tick_counter.sv
// Modulo-N cycle counter with enable and synchronous clear.
// tick is high while the count sits at N-1, i.e. on the last enabled
// cycle of each period; with N=1 tick is permanently high.
module cycle_tick_counter
   import conv_mem_pkg::*;
#(
   parameter int N = CONV1_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int             CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise advance and wrap at N-1 when enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/conv_mem_write_gen.sv
// Write-address generator for convolution output memories.
// Drives NUM_PORTS bank addresses that step together, one output per
// CYCLES_PER_OUT enabled cycles, under start/busy/done control.
// Optional build macro CONV_MEM_WR_HANDSHAKE_EN: replaces the fixed cycle
// counter with a data_valid input, so each enable & data_valid cycle
// writes one output.
module conv_mem_write_gen
   import conv_mem_pkg::*;
#(
   parameter int ADDR_W         = 10,
   parameter int NUM_PORTS      = 2,
   parameter int BASE_ADDR      = 0,
   parameter int PORT_STRIDE    = CONV1_STRIDE,
   parameter int OUTS_PER_PORT  = CONV1_OUTS,
   parameter int CYCLES_PER_OUT = CONV1_CYCLES,
   localparam int IDX_W = (OUTS_PER_PORT > 1) ? $clog2(OUTS_PER_PORT) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        enable,
`ifdef CONV_MEM_WR_HANDSHAKE_EN
   input  logic                        data_valid,
`endif
   output logic [NUM_PORTS*ADDR_W-1:0] addr,
   output logic                        we,
   output logic [IDX_W-1:0]            out_idx,
   output logic                        busy,
   output logic                        done
);

   // Base address of every port, packed port 0 in the low bits.
   function automatic logic [NUM_PORTS-1:0][ADDR_W-1:0] base_vec();
      logic [NUM_PORTS-1:0][ADDR_W-1:0] v;
      for (int p = 0; p < NUM_PORTS; p++) begin
         v[p] = ADDR_W'(BASE_ADDR + p * PORT_STRIDE);
      end
      return v;
   endfunction

   localparam logic [NUM_PORTS-1:0][ADDR_W-1:0] BASE_VEC = base_vec();
   localparam logic [IDX_W-1:0]                 LAST_IDX = IDX_W'(OUTS_PER_PORT - 1);

   // Reject configurations whose last address would wrap the address space.
   if (conv_last_addr(longint'(BASE_ADDR), longint'(PORT_STRIDE), NUM_PORTS,
                      OUTS_PER_PORT) >= (longint'(1) << ADDR_W)) begin : g_addr_range_err
      $error("conv_mem_write_gen: highest address does not fit in ADDR_W bits");
   end
   if (CYCLES_PER_OUT < 1) begin : g_cycles_err
      $error("conv_mem_write_gen: CYCLES_PER_OUT must be at least 1");
   end
   if (OUTS_PER_PORT < 1) begin : g_outs_err
      $error("conv_mem_write_gen: OUTS_PER_PORT must be at least 1");
   end

   state_e                           state_q;
   state_e                           state_d;
   logic [IDX_W-1:0]                 out_idx_q;
   logic [IDX_W-1:0]                 out_idx_d;
   logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_q;
   logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_d;
   logic                             done_q;
   logic                             done_d;

   logic start_acc;   // start honoured only outside RUN
   logic out_tick;    // this cycle completes one output when enabled
   logic we_int;

   assign start_acc = start & (state_q != ST_RUN);

`ifdef CONV_MEM_WR_HANDSHAKE_EN
   // The MAC pipeline says when a result is ready; no fixed cadence.
   assign out_tick = data_valid;
`else
   cycle_tick_counter #(
      .N (CYCLES_PER_OUT)
   ) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (start_acc),
      .en    ((state_q == ST_RUN) & enable),
      .tick  (out_tick)
   );
`endif

   assign we_int = (state_q == ST_RUN) & enable & out_tick;

   // Next-state and address/index update: load bases on an accepted start,
   // step all ports together after each write, park on the last write.
   always_comb begin
      state_d   = state_q;
      out_idx_d = out_idx_q;
      addr_d    = addr_q;
      done_d    = done_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_RUN;
               out_idx_d = '0;
               addr_d    = BASE_VEC;
               done_d    = 1'b0;
            end
         end
         ST_RUN: begin
            if (we_int) begin
               if (out_idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  out_idx_d = out_idx_q + IDX_W'(1);
                  for (int p = 0; p < NUM_PORTS; p++) begin
                     addr_d[p] = addr_q[p] + ADDR_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, index, address and done registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         out_idx_q <= '0;
         addr_q    <= BASE_VEC;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_idx_q <= out_idx_d;
         addr_q    <= addr_d;
         done_q    <= done_d;
      end
   end

   assign addr    = addr_q;
   assign we      = we_int;
   assign out_idx = out_idx_q;
   assign busy    = (state_q == ST_RUN);
   assign done    = done_q;

endmodule
